fetch_unit: RTL and testbench

- Parametrised instruction-fetch front end for the RV32I pipeline; replaces the bare PC/MAR fetch stage.
- Holds the fetch PC and issues sequential requests to instruction memory with a valid/ready handshake.
- Tolerates variable response latency, buffers returned instructions with their PCs in a DEPTH-entry prefetch queue, and delivers them to decode with a valid/ready handshake.
- Handles branch/jump redirects from the memory stage: flushes the queue and discards stale in-flight responses.

---
 rtl/fetch_unit_if.sv | 32 +++
 rtl/fetch_unit.sv | 131 +++++++++++++
 tb/tb_fetch_unit.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_unit_if.sv
// Fetch front-end bus bundle: instruction-memory request/response, redirect and decode-side signals.
// master = fetch unit, slave = memory/decode/memory-stage side (or a testbench).
interface fetch_unit_if #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_resp_valid;
  logic [31:0]     imem_resp_data;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            id_valid;
  logic            id_ready;
  logic [31:0]     id_instr;
  logic [XLEN-1:0] id_pc;
  logic [CW-1:0]   q_count;
  logic            misaligned;

  modport master (
    output imem_req_valid, imem_req_addr, id_valid, id_instr, id_pc, q_count, misaligned,
    input  imem_req_ready, imem_resp_valid, imem_resp_data, redirect_valid, redirect_pc, id_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, id_valid, id_instr, id_pc, q_count, misaligned,
    output imem_req_ready, imem_resp_valid, imem_resp_data, redirect_valid, redirect_pc, id_ready
  );
endinterface

// File: rtl/fetch_unit.sv
// RV32I instruction-fetch front end: credit-limited sequential fetch, in-order prefetch queue, redirect flush.
// Optional FETCH_ALIGN_CHECK_EN: misaligned redirect targets raise misaligned and halt fetch until an aligned redirect.
module fetch_unit #(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic      clk,
  input  logic      rst,
  fetch_unit_if.master bus
);

  localparam int              PW      = $clog2(DEPTH);
  localparam int              CW      = PW + 1;
  localparam logic [CW:0]     DEPTH_W = (CW+1)'(DEPTH);
  localparam logic [XLEN-1:0] ALIGN_M = {{(XLEN-2){1'b1}}, 2'b00};

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_chk
    $error("fetch_unit: DEPTH must be a power of two, at least 2");
  end

  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
    return pc & ALIGN_M;
  endfunction

  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] resp_pc;
  logic [CW-1:0]   outstanding;
  logic [CW-1:0]   outstanding_nx;
  logic [CW-1:0]   discard;
  logic [CW-1:0]   count;
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [31:0]     q_instr [DEPTH];
  logic [XLEN-1:0] q_pc    [DEPTH];
  logic            halted;

  logic [CW:0]     inflight;
  logic            credit_ok;
  logic            redir;
  logic [XLEN-1:0] target;
  logic            drop;
  logic            push;
  logic            pop;
  logic            req_fire;

  // Request/response/queue decisions for this cycle
  always_comb begin
    inflight       = {1'b0, count} + {1'b0, outstanding};
    credit_ok      = inflight < DEPTH_W;
    redir          = bus.redirect_valid;
    target         = align_pc(bus.redirect_pc);
    drop           = discard != '0;
    push           = bus.imem_resp_valid && !drop && !redir;
    pop            = (count != '0) && bus.id_ready && !redir;
    req_fire       = bus.imem_req_valid && bus.imem_req_ready;
    outstanding_nx = outstanding + CW'(req_fire) - CW'(bus.imem_resp_valid);
  end

  assign bus.imem_req_valid = !rst && !halted && credit_ok && !redir;
  assign bus.imem_req_addr  = fetch_pc;

  // Control state; the PC tag counter tracks the address of the next non-discarded response
  always_ff @(negedge clk) begin
    if (rst) begin
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      outstanding <= '0;
      discard     <= '0;
      count       <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
    end else begin
      outstanding <= outstanding_nx;
      if (redir) begin
        // Everything still in flight after this cycle belongs to the old path
        fetch_pc <= target;
        resp_pc  <= target;
        discard  <= outstanding_nx;
        count    <= '0;
        wr_ptr   <= '0;
        rd_ptr   <= '0;
      end else begin
        if (req_fire)
          fetch_pc <= fetch_pc + XLEN'(4);
        if (bus.imem_resp_valid && drop)
          discard <= discard - CW'(1);
        if (push) begin
          wr_ptr  <= wr_ptr + 1'b1;
          resp_pc <= resp_pc + XLEN'(4);
        end
        if (pop)
          rd_ptr <= rd_ptr + 1'b1;
        count <= count + CW'(push) - CW'(pop);
      end
    end
  end

  // Queue storage holds data only, so it carries no reset
  always_ff @(negedge clk) begin
    if (push) begin
      q_instr[wr_ptr] <= bus.imem_resp_data;
      q_pc[wr_ptr]    <= resp_pc;
    end
  end

  assign bus.id_valid = count != '0;
  assign bus.id_instr = q_instr[rd_ptr];
  assign bus.id_pc    = q_pc[rd_ptr];
  assign bus.q_count  = count;

`ifdef FETCH_ALIGN_CHECK_EN
  logic misaligned_q;

  always_ff @(negedge clk) begin
    if (rst) begin
      misaligned_q <= 1'b0;
      halted       <= 1'b0;
    end else if (redir) begin
      misaligned_q <= |bus.redirect_pc[1:0];
      halted       <= |bus.redirect_pc[1:0];
    end
  end

  assign bus.misaligned = misaligned_q;
`else
  assign halted         = 1'b0;
  assign bus.misaligned = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed table-driven bench for fetch_unit with an in-order variable-latency instruction memory model.
module tb_fetch_unit;

  localparam int          XLEN  = 32;
  localparam int          DEPTH = 4;
  localparam logic [31:0] KEY   = 32'h0013_A5A5;
`ifdef FETCH_ALIGN_CHECK_EN
  localparam bit AL = 1'b1;
`else
  localparam bit AL = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fetch_unit_if #(.XLEN(XLEN), .DEPTH(DEPTH)) bus ();

  fetch_unit #(.XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    bit          rs;
    bit          rv;
    logic [31:0] rp;
    bit          ir;
    bit          qr;
    int          lat;
    bit          chk;
    bit          erv;
    logic [31:0] ea;
    bit          eiv;
    logic [31:0] ep;
    int          eqc;
    bit          em;
  } vec_t;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;

  vec_t  vec[$];
  mreq_t mq[$];
  int    n_tests = 0;
  int    n_fail  = 0;
  int    cyc     = 0;
  int    f_ir    = 1;
  int    f_qr    = 1;
  int    f_lat   = 1;

  function automatic void rst_row(int lat);
    vec_t v;
    f_lat = lat;
    v = '{rs: 1'b1, rv: 1'b0, rp: 32'h0, ir: 1'b1, qr: 1'b1, lat: lat, chk: 1'b0,
          erv: 1'b0, ea: 32'h0, eiv: 1'b0, ep: 32'h0, eqc: 0, em: 1'b0};
    vec.push_back(v);
  endfunction

  function automatic void s(int rv, logic [31:0] rp, int erv, logic [31:0] ea,
                            int eiv, logic [31:0] ep, int eqc, int em);
    vec_t v;
    v = '{rs: 1'b0, rv: rv != 0, rp: rp, ir: f_ir != 0, qr: f_qr != 0, lat: f_lat, chk: 1'b1,
          erv: erv != 0, ea: ea, eiv: eiv != 0, ep: ep, eqc: eqc, em: em != 0};
    vec.push_back(v);
  endfunction

  task automatic check(input string nm, input int row, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s row %0d: got %h, expected %h", nm, row, act, exp);
    end
  endtask

  initial begin
    // Steady-state sequential fetch, latency 1, decode always ready
    f_ir = 1; f_qr = 1;
    rst_row(1);
    s(0, 0, 1, 32'h0,  0, 0,     0, 0);
    s(0, 0, 1, 32'h4,  0, 0,     0, 0);
    s(0, 0, 1, 32'h8,  1, 32'h0, 1, 0);
    s(0, 0, 1, 32'hC,  1, 32'h4, 1, 0);
    s(0, 0, 1, 32'h10, 1, 32'h8, 1, 0);

    // Decode stalled: credit limit fills the queue, then drain and resume at 16
    rst_row(1);
    f_ir = 0;
    s(0, 0, 1, 32'h0, 0, 0,     0, 0);
    s(0, 0, 1, 32'h4, 0, 0,     0, 0);
    s(0, 0, 1, 32'h8, 1, 32'h0, 1, 0);
    s(0, 0, 1, 32'hC, 1, 32'h0, 2, 0);
    s(0, 0, 0, 0,     1, 32'h0, 3, 0);
    s(0, 0, 0, 0,     1, 32'h0, 4, 0);
    f_ir = 1;
    s(0, 0, 0, 0,      1, 32'h0,  4, 0);
    s(0, 0, 1, 32'h10, 1, 32'h4,  3, 0);
    s(0, 0, 1, 32'h14, 1, 32'h8,  2, 0);
    s(0, 0, 1, 32'h18, 1, 32'hC,  2, 0);
    s(0, 0, 1, 32'h1C, 1, 32'h10, 2, 0);

    // Latency 3, redirect with three requests outstanding
    rst_row(3);
    s(0, 0,      1, 32'h0,   0, 0,       0, 0);
    s(0, 0,      1, 32'h4,   0, 0,       0, 0);
    s(0, 0,      1, 32'h8,   0, 0,       0, 0);
    s(1, 32'h100, 0, 0,      0, 0,       0, 0);
    s(0, 0,      1, 32'h100, 0, 0,       0, 0);
    s(0, 0,      1, 32'h104, 0, 0,       0, 0);
    s(0, 0,      1, 32'h108, 0, 0,       0, 0);
    s(0, 0,      1, 32'h10C, 0, 0,       0, 0);
    s(0, 0,      0, 0,       1, 32'h100, 1, 0);
    s(0, 0,      1, 32'h110, 1, 32'h104, 1, 0);
    s(0, 0,      1, 32'h114, 1, 32'h108, 1, 0);

    // Redirect coinciding with a pop and an arriving response
    rst_row(1);
    f_ir = 0;
    s(0, 0, 1, 32'h0, 0, 0,     0, 0);
    s(0, 0, 1, 32'h4, 0, 0,     0, 0);
    s(0, 0, 1, 32'h8, 1, 32'h0, 1, 0);
    f_ir = 1;
    s(1, 32'h40, 0, 0,     1, 32'h0,  2, 0);
    s(0, 0,      1, 32'h40, 0, 0,      0, 0);
    s(0, 0,      1, 32'h44, 0, 0,      0, 0);
    s(0, 0,      1, 32'h48, 1, 32'h40, 1, 0);

    // Back-to-back redirects, latency 3: the second target wins
    rst_row(3);
    s(0, 0,       1, 32'h0,   0, 0,       0, 0);
    s(0, 0,       1, 32'h4,   0, 0,       0, 0);
    s(1, 32'h80,  0, 0,       0, 0,       0, 0);
    s(1, 32'h300, 0, 0,       0, 0,       0, 0);
    s(0, 0,       1, 32'h300, 0, 0,       0, 0);
    s(0, 0,       1, 32'h304, 0, 0,       0, 0);
    s(0, 0,       1, 32'h308, 0, 0,       0, 0);
    s(0, 0,       1, 32'h30C, 0, 0,       0, 0);
    s(0, 0,       0, 0,       1, 32'h300, 1, 0);

    // PC wrap at the top of the address space
    rst_row(1);
    s(1, 32'hFFFF_FFFC, 0, 0,            0, 0,            0, 0);
    s(0, 0,             1, 32'hFFFF_FFFC, 0, 0,            0, 0);
    s(0, 0,             1, 32'h0,         0, 0,            0, 0);
    s(0, 0,             1, 32'h4,         1, 32'hFFFF_FFFC, 1, 0);
    s(0, 0,             1, 32'h8,         1, 32'h0,         1, 0);

    // Memory not ready: address holds until accepted
    rst_row(1);
    f_qr = 0;
    s(0, 0, 1, 32'h0, 0, 0, 0, 0);
    s(0, 0, 1, 32'h0, 0, 0, 0, 0);
    f_qr = 1;
    s(0, 0, 1, 32'h0, 0, 0,     0, 0);
    s(0, 0, 1, 32'h4, 0, 0,     0, 0);
    s(0, 0, 1, 32'h8, 1, 32'h0, 1, 0);

    // Misaligned redirect target, recovery, then reset clearing the flag
    rst_row(1);
    s(1, 32'h102, 0, 0, 0, 0, 0, 0);
    for (int k = 2; k < 12; k++)
      s(0, 0, !AL, 32'h100 + 4*(k-2), (!AL && k >= 4), 32'h100 + 4*(k-4),
        (!AL && k >= 4) ? 1 : 0, AL);
    s(1, 32'h200, 0, 0,       !AL, 32'h120, !AL ? 1 : 0, AL);
    s(0, 0,       1, 32'h200, 0,   0,       0, 0);
    s(0, 0,       1, 32'h204, 0,   0,       0, 0);
    s(0, 0,       1, 32'h208, 1,   32'h200, 1, 0);
    s(1, 32'h103, 0, 0,       1,   32'h204, 1, 0);
    s(0, 0,       !AL, 32'h100, 0, 0,       0, AL);
    rst_row(1);
    s(0, 0,       1, 32'h0,   0,   0,       0, 0);

    bus.redirect_valid  = 1'b0;
    bus.redirect_pc     = '0;
    bus.id_ready        = 1'b0;
    bus.imem_req_ready  = 1'b0;
    bus.imem_resp_valid = 1'b0;
    bus.imem_resp_data  = '0;
    rst                 = 1'b1;

    for (int i = 0; i < vec.size(); i++) begin
      vec_t v;
      v = vec[i];
      rst                = v.rs;
      bus.redirect_valid = v.rv;
      bus.redirect_pc    = v.rp;
      bus.id_ready       = v.ir;
      bus.imem_req_ready = v.qr;
      if (v.rs) begin
        mq.delete();
        bus.imem_resp_valid = 1'b0;
        bus.imem_resp_data  = '0;
      end else if (mq.size() != 0 && mq[0].due <= cyc) begin
        bus.imem_resp_valid = 1'b1;
        bus.imem_resp_data  = mq[0].addr ^ KEY;
        void'(mq.pop_front());
      end else begin
        bus.imem_resp_valid = 1'b0;
        bus.imem_resp_data  = '0;
      end

      @(posedge clk);
      check("req_valid", i, 32'(bus.imem_req_valid), 32'(v.erv));
      if (v.erv)
        check("req_addr", i, bus.imem_req_addr, v.ea);
      if (v.chk) begin
        check("id_valid", i, 32'(bus.id_valid), 32'(v.eiv));
        check("q_count", i, 32'(bus.q_count), 32'(v.eqc));
        check("misaligned", i, 32'(bus.misaligned), 32'(v.em));
        if (v.eiv) begin
          check("id_pc", i, bus.id_pc, v.ep);
          check("id_instr", i, bus.id_instr, v.ep ^ KEY);
        end
      end
      check("q_overflow", i, 32'(int'(bus.q_count) > DEPTH), 32'h0);
      if (bus.imem_req_valid && bus.imem_req_ready)
        mq.push_back('{addr: bus.imem_req_addr, due: cyc + v.lat});

      @(negedge clk);
      #1;
      cyc++;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
